// File: rtl/sram_like_arbiter.sv
// sram_like_arbiter
//   Shares one SRAM-like slave port between the instruction-fetch and the
//   load/store requesters of the core. One request is picked per cycle.
//   Data wins by default. Instruction fetch is forced through after
//   STARVE_LIMIT consecutive data grants made while it was waiting. A
//   grant that the slave has not accepted is held until bus_addr_ok.
//   The owner of every accepted request goes into an in-order tag FIFO.
//   Each returning response is then routed to the requester at the FIFO
//   head.
//
// Ports
//   clk, reset                 clock, synchronous active-high reset
//   inst_req/inst_cmd          instruction requester (cmd is 72-bit packed)
//   inst_addr_ok/data_ok/rdata instruction requester handshake and read data
//   data_req/data_cmd          load/store requester
//   data_addr_ok/data_ok/rdata load/store requester handshake and read data
//   bus_req/bus_cmd            request to the slave
//   bus_addr_ok/data_ok/rdata  slave handshake and read data
//   outstanding_cnt            tag FIFO occupancy
//   resp_err                   one-cycle pulse after a response arrived with no owner
module sram_like_arbiter #(
    parameter int MAX_OUTSTANDING = 4,
    parameter int STARVE_LIMIT    = 4
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 inst_req,
    input  logic [71:0]                          inst_cmd,
    output logic                                 inst_addr_ok,
    output logic                                 inst_data_ok,
    output logic [31:0]                          inst_rdata,
    input  logic                                 data_req,
    input  logic [71:0]                          data_cmd,
    output logic                                 data_addr_ok,
    output logic                                 data_data_ok,
    output logic [31:0]                          data_rdata,
    output logic                                 bus_req,
    output logic [71:0]                          bus_cmd,
    input  logic                                 bus_addr_ok,
    input  logic                                 bus_data_ok,
    input  logic [31:0]                          bus_rdata,
    output logic [$clog2(MAX_OUTSTANDING):0]     outstanding_cnt,
    output logic                                 resp_err
);
    localparam int PW = $clog2(MAX_OUTSTANDING);
    localparam int CW = PW + 1;
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [1:0] {IDLE, LOCK_INST, LOCK_DATA} state_t;

    state_t                     state, state_nxt;
    logic [PW-1:0]              wr_ptr, rd_ptr;
    logic [CW-1:0]              count;
    logic [MAX_OUTSTANDING-1:0] tag_q;      // 0 = inst, 1 = data
    logic [SW-1:0]              starve_cnt;

    logic req_sel, grant_data, accept, pop, full, can_issue, starved, head;

    assign full    = (count == CW'(MAX_OUTSTANDING));
    // A response popping this cycle frees a slot, so a full FIFO can still issue.
    assign pop       = bus_data_ok && (count != '0) && !reset;
    assign can_issue = !full || pop;
    assign starved   = inst_req && (starve_cnt == SW'(STARVE_LIMIT));
    assign head      = tag_q[rd_ptr];

    always_comb begin
        req_sel    = 1'b0;
        grant_data = 1'b0;
        state_nxt  = state;
        case (state)
            IDLE: begin
                if (can_issue) begin
                    if (data_req && !starved) begin
                        req_sel    = 1'b1;
                        grant_data = 1'b1;
                    end else if (inst_req) begin
                        req_sel = 1'b1;
                    end
                end
                if (req_sel && !bus_addr_ok)
                    state_nxt = grant_data ? LOCK_DATA : LOCK_INST;
            end
            LOCK_INST: begin
                req_sel = inst_req;
                // A dropped request would otherwise wedge the lock.
                if (!inst_req || bus_addr_ok) state_nxt = IDLE;
            end
            LOCK_DATA: begin
                req_sel    = data_req;
                grant_data = 1'b1;
                if (!data_req || bus_addr_ok) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign bus_req      = req_sel && !reset;
    assign bus_cmd      = grant_data ? data_cmd : inst_cmd;
    assign accept       = bus_req && bus_addr_ok;
    assign inst_addr_ok = accept && !grant_data;
    assign data_addr_ok = accept && grant_data;

    // The head is read before any same-cycle push, so it always names the oldest owner.
    assign inst_data_ok = pop && !head;
    assign data_data_ok = pop && head;
    assign inst_rdata   = bus_rdata;
    assign data_rdata   = bus_rdata;

    assign outstanding_cnt = count;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            tag_q      <= '0;
            starve_cnt <= '0;
            resp_err   <= 1'b0;
        end else begin
            state    <= state_nxt;
            resp_err <= bus_data_ok && (count == '0);
            if (accept) begin
                tag_q[wr_ptr] <= grant_data;
                wr_ptr        <= wr_ptr + PW'(1);
                if (grant_data && inst_req) begin
                    if (starve_cnt != SW'(STARVE_LIMIT))
                        starve_cnt <= starve_cnt + SW'(1);
                end else begin
                    starve_cnt <= '0;
                end
            end
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            case ({accept, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// File: tb/tb_sram_like_arbiter.sv
// Directed bench for sram_like_arbiter. A second instance with a deeper FIFO
// shares the inputs so the starvation sequence can run without responses.
module tb_sram_like_arbiter;
    logic        clk = 1'b0;
    logic        reset;
    logic        inst_req, data_req, bus_addr_ok, bus_data_ok;
    logic [71:0] inst_cmd, data_cmd;
    logic [31:0] bus_rdata;

    logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok, bus_req, resp_err;
    logic [31:0] inst_rdata, data_rdata;
    logic [71:0] bus_cmd;
    logic [2:0]  cnt;

    logic        o8_inst_addr_ok, o8_inst_data_ok, o8_data_addr_ok, o8_data_data_ok;
    logic        o8_bus_req, o8_resp_err;
    logic [31:0] o8_inst_rdata, o8_data_rdata;
    logic [71:0] o8_bus_cmd;
    logic [3:0]  o8_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sram_like_arbiter #(.MAX_OUTSTANDING(4), .STARVE_LIMIT(4)) dut (
        .clk(clk), .reset(reset),
        .inst_req(inst_req), .inst_cmd(inst_cmd), .inst_addr_ok(inst_addr_ok),
        .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_cmd(data_cmd), .data_addr_ok(data_addr_ok),
        .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .bus_req(bus_req), .bus_cmd(bus_cmd), .bus_addr_ok(bus_addr_ok),
        .bus_data_ok(bus_data_ok), .bus_rdata(bus_rdata),
        .outstanding_cnt(cnt), .resp_err(resp_err));

    sram_like_arbiter #(.MAX_OUTSTANDING(8), .STARVE_LIMIT(4)) dut8 (
        .clk(clk), .reset(reset),
        .inst_req(inst_req), .inst_cmd(inst_cmd), .inst_addr_ok(o8_inst_addr_ok),
        .inst_data_ok(o8_inst_data_ok), .inst_rdata(o8_inst_rdata),
        .data_req(data_req), .data_cmd(data_cmd), .data_addr_ok(o8_data_addr_ok),
        .data_data_ok(o8_data_data_ok), .data_rdata(o8_data_rdata),
        .bus_req(o8_bus_req), .bus_cmd(o8_bus_cmd), .bus_addr_ok(bus_addr_ok),
        .bus_data_ok(bus_data_ok), .bus_rdata(bus_rdata),
        .outstanding_cnt(o8_cnt), .resp_err(o8_resp_err));

    function automatic logic [71:0] mk_cmd(input logic wr, input logic [31:0] addr, input logic [31:0] wd);
        return {wr, 2'b10, 4'hF, addr, wd, 1'b0};
    endfunction

    // Inputs change 1 time unit after the rising edge; comb outputs are checked 1 unit later.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs;
        inst_req = 0; data_req = 0; bus_addr_ok = 0; bus_data_ok = 0; bus_rdata = '0;
        inst_cmd = mk_cmd(1'b0, 32'h1C00_0000, 32'h0);
        data_cmd = mk_cmd(1'b1, 32'h8000_0100, 32'hDEAD_BEEF);
    endtask

    task automatic do_reset;
        clear_inputs();
        reset = 1;
        tick(); tick();
        reset = 0;
    endtask

    task automatic test_reset;
        clear_inputs();
        reset = 1;
        tick();
        inst_req = 1; data_req = 1; bus_addr_ok = 1; bus_data_ok = 1;
        #1;
        checks++; if (bus_req !== 1'b0) begin errors++; $display("FAIL rst_bus_req got %b exp 0", bus_req); end
        checks++; if ({inst_addr_ok, data_addr_ok} !== 2'b00) begin errors++; $display("FAIL rst_addr_ok got %b exp 00", {inst_addr_ok, data_addr_ok}); end
        checks++; if ({inst_data_ok, data_data_ok} !== 2'b00) begin errors++; $display("FAIL rst_data_ok got %b exp 00", {inst_data_ok, data_data_ok}); end
        tick();
        checks++; if (cnt !== 3'd0 || resp_err !== 1'b0) begin errors++; $display("FAIL rst_state cnt %0d err %b exp 0 0", cnt, resp_err); end
        clear_inputs();
        reset = 0;
        tick();
    endtask

    task automatic test_inst_only;
        do_reset();
        inst_req = 1; inst_cmd = mk_cmd(1'b0, 32'h1C00_0000, 32'h0); bus_addr_ok = 1;
        #1;
        checks++; if (inst_addr_ok !== 1'b1 || data_addr_ok !== 1'b0) begin errors++; $display("FAIL io_addr_ok got %b%b exp 10", inst_addr_ok, data_addr_ok); end
        checks++; if (bus_cmd[64:33] !== 32'h1C00_0000) begin errors++; $display("FAIL io_bus_addr got %h exp 1c000000", bus_cmd[64:33]); end
        checks++; if (cnt !== 3'd0) begin errors++; $display("FAIL io_cnt0 got %0d exp 0", cnt); end
        tick();
        inst_req = 0; bus_addr_ok = 0;
        #1;
        checks++; if (cnt !== 3'd1) begin errors++; $display("FAIL io_cnt1 got %0d exp 1", cnt); end
        tick();
        bus_data_ok = 1; bus_rdata = 32'h0280_0C0C;
        #1;
        checks++; if (inst_data_ok !== 1'b1 || data_data_ok !== 1'b0) begin errors++; $display("FAIL io_data_ok got %b%b exp 10", inst_data_ok, data_data_ok); end
        checks++; if (inst_rdata !== 32'h0280_0C0C) begin errors++; $display("FAIL io_rdata got %h exp 02800c0c", inst_rdata); end
        tick();
        bus_data_ok = 0;
        #1;
        checks++; if (cnt !== 3'd0) begin errors++; $display("FAIL io_cnt_end got %0d exp 0", cnt); end
    endtask

    task automatic test_starve;
        logic [7:0] seq;
        seq = 8'b0010_1111;  // LSB first, 1 = data grant: D D D D I D I I
        do_reset();
        inst_req = 1; bus_addr_ok = 1;
        for (int i = 0; i < 8; i++) begin
            data_req = (i < 6);
            #1;
            checks++;
            if (o8_data_addr_ok !== seq[i] || o8_inst_addr_ok !== !seq[i]) begin
                errors++; $display("FAIL starve_grant%0d got d%b i%b exp d%b", i, o8_data_addr_ok, o8_inst_addr_ok, seq[i]);
            end
            tick();
        end
        #1;
        checks++; if (o8_cnt !== 4'd8) begin errors++; $display("FAIL starve_cnt got %0d exp 8", o8_cnt); end
    endtask

    task automatic test_lock;
        logic [71:0] dc;
        dc = mk_cmd(1'b1, 32'h8000_0200, 32'h1234_5678);
        do_reset();
        data_req = 1; data_cmd = dc;
        for (int c = 1; c <= 3; c++) begin
            if (c == 2) inst_req = 1;
            #1;
            checks++; if (bus_req !== 1'b1 || bus_cmd !== dc) begin errors++; $display("FAIL lock_cmd c%0d got req %b cmd %h exp data", c, bus_req, bus_cmd); end
            checks++; if (data_addr_ok !== 1'b0 || inst_addr_ok !== 1'b0) begin errors++; $display("FAIL lock_addr_ok c%0d got %b%b exp 00", c, inst_addr_ok, data_addr_ok); end
            tick();
        end
        bus_addr_ok = 1;
        #1;
        checks++; if (data_addr_ok !== 1'b1 || inst_addr_ok !== 1'b0 || bus_cmd !== dc) begin errors++; $display("FAIL lock_accept got i%b d%b exp d", inst_addr_ok, data_addr_ok); end
        tick();
        data_req = 0;
        #1;
        checks++; if (inst_addr_ok !== 1'b1) begin errors++; $display("FAIL lock_after got %b exp 1", inst_addr_ok); end
        tick();
        inst_req = 0; bus_addr_ok = 0;
        #1;
        checks++; if (cnt !== 3'd2) begin errors++; $display("FAIL lock_cnt got %0d exp 2", cnt); end
    endtask

    task automatic test_full;
        do_reset();
        inst_req = 1; bus_addr_ok = 1;
        tick(); tick(); tick(); tick();
        #1;
        checks++; if (cnt !== 3'd4) begin errors++; $display("FAIL full_cnt got %0d exp 4", cnt); end
        checks++; if (bus_req !== 1'b0 || inst_addr_ok !== 1'b0) begin errors++; $display("FAIL full_block got req %b ok %b exp 0 0", bus_req, inst_addr_ok); end
        tick();
        bus_data_ok = 1; bus_rdata = 32'hA5A5_0001;
        #1;
        checks++; if (inst_data_ok !== 1'b1 || inst_rdata !== 32'hA5A5_0001) begin errors++; $display("FAIL full_resp got %b %h exp 1 a5a50001", inst_data_ok, inst_rdata); end
        checks++; if (bus_req !== 1'b1 || inst_addr_ok !== 1'b1) begin errors++; $display("FAIL full_reissue got req %b ok %b exp 1 1", bus_req, inst_addr_ok); end
        tick();
        inst_req = 0; bus_addr_ok = 0; bus_data_ok = 0;
        #1;
        checks++; if (cnt !== 3'd4) begin errors++; $display("FAIL full_pushpop got %0d exp 4", cnt); end
    endtask

    task automatic test_ordering;
        logic [3:0]  owner;
        logic [31:0] r [4];
        owner = 4'b0110;  // LSB first: I D D I
        r[0] = 32'h1111_0000; r[1] = 32'h2222_0001; r[2] = 32'h3333_0002; r[3] = 32'h4444_0003;
        do_reset();
        bus_addr_ok = 1;
        for (int i = 0; i < 4; i++) begin
            inst_req = !owner[i]; data_req = owner[i];
            tick();
        end
        inst_req = 0; data_req = 0; bus_addr_ok = 0;
        for (int i = 0; i < 4; i++) begin
            bus_data_ok = 1; bus_rdata = r[i];
            #1;
            checks++;
            if (data_data_ok !== owner[i] || inst_data_ok !== !owner[i] || (owner[i] ? data_rdata : inst_rdata) !== r[i]) begin
                errors++; $display("FAIL order%0d got i%b d%b %h exp d%b %h", i, inst_data_ok, data_data_ok, bus_rdata, owner[i], r[i]);
            end
            tick();
        end
        bus_data_ok = 0;
        #1;
        checks++; if (cnt !== 3'd0) begin errors++; $display("FAIL order_cnt got %0d exp 0", cnt); end
    endtask

    task automatic test_spurious_reset;
        bus_data_ok = 1; bus_rdata = 32'hBAD0_0000;
        #1;
        checks++; if (inst_data_ok !== 1'b0 || data_data_ok !== 1'b0 || resp_err !== 1'b0) begin errors++; $display("FAIL spur_now got i%b d%b e%b exp 000", inst_data_ok, data_data_ok, resp_err); end
        tick();
        bus_data_ok = 0;
        #1;
        checks++; if (resp_err !== 1'b1 || cnt !== 3'd0) begin errors++; $display("FAIL spur_err got e%b cnt %0d exp 1 0", resp_err, cnt); end
        tick();
        #1;
        checks++; if (resp_err !== 1'b0) begin errors++; $display("FAIL spur_pulse got %b exp 0", resp_err); end
        inst_req = 1; bus_addr_ok = 1;
        tick(); tick(); tick();
        inst_req = 0; data_req = 1; bus_addr_ok = 0;  // park a data grant in the lock
        #1;
        checks++; if (cnt !== 3'd3) begin errors++; $display("FAIL mid_cnt got %0d exp 3", cnt); end
        tick();
        reset = 1;
        tick();
        reset = 0; data_req = 0; inst_req = 1; bus_addr_ok = 1;
        #1;
        checks++; if (cnt !== 3'd0) begin errors++; $display("FAIL rst_cnt got %0d exp 0", cnt); end
        checks++; if (inst_addr_ok !== 1'b1 || bus_cmd !== inst_cmd) begin errors++; $display("FAIL rst_idle got %b exp 1", inst_addr_ok); end
        tick();
        clear_inputs();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_inputs();
        reset = 1;
        test_reset();
        test_inst_only();
        test_starve();
        test_lock();
        test_full();
        test_ordering();
        test_spurious_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
